// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer, mid-bit sampling and a one-byte output register.
// Byte visible 2+BIT_CYC/2+9*BIT_CYC edges after the start edge; rdy_rx never stalls reception, and a full register drops the new byte and pulses ovr_rx.
module uart_rx #(
  parameter int BIT_CYC = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  input  logic       rdy_rx,
  output logic       vld_rx,
  output logic [7:0] d_rx,
  output logic       err_rx,
  output logic       ovr_rx
);

  localparam int CW = $clog2(BIT_CYC);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CYC - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;
  logic            rx_s1, rxs;
  logic            half_hit, full_hit;
  logic            shift_en, done, frm_err, xfer;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rxs   <= rx_s1;
    end
  end

  assign half_hit = (cnt == HALF_M1);
  assign full_hit = (cnt == FULL_M1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rxs) state_nxt = START;
      START: if (half_hit) state_nxt = rxs ? IDLE : DATA;
      DATA:  if (full_hit && idx == 3'd7) state_nxt = STOP;
      STOP:  if (full_hit) state_nxt = rxs ? IDLE : BRK;
      BRK:   if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_en = (state == DATA) && full_hit;
    done     = (state == STOP) && full_hit && rxs;
    frm_err  = (state == STOP) && full_hit && !rxs;
  end

  // Counter restarts at every sampling point so each bit is timed from the previous sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      idx   <= 3'd0;
      shreg <= 8'h00;
    end else begin
      case (state)
        START: begin
          cnt <= half_hit ? '0 : cnt + CW'(1);
          if (half_hit) idx <= 3'd0;
        end
        DATA, STOP: cnt <= full_hit ? '0 : cnt + CW'(1);
        default: cnt <= '0;
      endcase
      if (shift_en) begin
        shreg <= {rxs, shreg[7:1]};
        idx   <= idx + 3'd1;
      end
    end
  end

  assign xfer = vld_rx && rdy_rx;

  // A transfer on the completion edge frees the register, so the new byte takes its place.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_rx <= 1'b0;
      d_rx   <= 8'h00;
      err_rx <= 1'b0;
      ovr_rx <= 1'b0;
    end else begin
      if (done && (!vld_rx || xfer)) begin
        d_rx   <= shreg;
        vld_rx <= 1'b1;
      end else if (xfer) begin
        vld_rx <= 1'b0;
      end
      err_rx <= frm_err;
      ovr_rx <= done && vld_rx && !xfer;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BIT_CYC=16: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx;

  localparam int BC   = 16;
  localparam int COMP = 2 + BC / 2 + 9 * BC;   // start edge to stop-sample edge

  logic       clk, rstn, rxd, rdy_rx;
  logic       vld_rx, err_rx, ovr_rx;
  logic [7:0] d_rx;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int err_cnt = 0, ovr_cnt = 0, vld_hi_cnt = 0;

  typedef struct {
    int         edge_n;
    logic [7:0] b;
    logic       good;
  } frm_t;
  frm_t fq[$];

  logic       exp_vld, exp_err, exp_ovr;
  logic [7:0] exp_d;
  logic       done;

  uart_rx #(.BIT_CYC(BC)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .rxd    (rxd),
    .rdy_rx (rdy_rx),
    .vld_rx (vld_rx),
    .d_rx   (d_rx),
    .err_rx (err_rx),
    .ovr_rx (ovr_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level reference: each frame resolves at its stop-sample edge.
  initial begin
    logic xfer;
    exp_vld = 1'b0; exp_d = 8'h00; exp_err = 1'b0; exp_ovr = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      exp_err = 1'b0;
      exp_ovr = 1'b0;
      if (!rstn) begin
        exp_vld = 1'b0;
        exp_d   = 8'h00;
        fq.delete();
      end else begin
        xfer = exp_vld && rdy_rx;
        if (xfer) exp_vld = 1'b0;
        if (fq.size() > 0 && fq[0].edge_n == cyc) begin
          if (!fq[0].good)   exp_err = 1'b1;
          else if (!exp_vld) begin exp_d = fq[0].b; exp_vld = 1'b1; end
          else               exp_ovr = 1'b1;
          void'(fq.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (err_rx) err_cnt++;
      if (ovr_rx) ovr_cnt++;
      if (vld_rx) vld_hi_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a falling clock edge; the next rising edge is edge 0.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    frm_t f;
    f.edge_n = cyc + 1 + COMP;
    f.b      = b;
    f.good   = stop;
    fq.push_back(f);
    rxd = 1'b0;
    repeat (BC) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      repeat (BC) @(negedge clk);
    end
    rxd = stop;
    repeat (BC) @(negedge clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0; rxd = 1'b1; rdy_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vld_rx !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", vld_rx); end
    checks++; if (d_rx !== 8'h00)  begin errors++; $display("FAIL reset_d: got %h want 00", d_rx); end
    checks++; if (err_rx !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_rx); end
    checks++; if (ovr_rx !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", ovr_rx); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_hold;
    int s;
    @(negedge clk);
    rdy_rx = 1'b0;
    s = cyc + 1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_edge(s + COMP - 1);
        checks++; if (vld_rx !== 1'b0) begin errors++; $display("FAIL a5_early_vld: got %b want 0", vld_rx); end
        wait_edge(s + COMP);
        checks++; if (vld_rx !== 1'b1) begin errors++; $display("FAIL a5_vld: got %b want 1", vld_rx); end
        checks++; if (d_rx !== 8'hA5)  begin errors++; $display("FAIL a5_data: got %h want a5", d_rx); end
      end
    join
    repeat (10) @(negedge clk);
    checks++; if (vld_rx !== 1'b1 || d_rx !== 8'hA5) begin errors++; $display("FAIL a5_hold: got vld=%b d=%h want 1/a5", vld_rx, d_rx); end
    rdy_rx = 1'b1;
    @(posedge clk); #1;
    checks++; if (vld_rx !== 1'b0) begin errors++; $display("FAIL a5_consume: got %b want 0", vld_rx); end
    @(negedge clk);
    rdy_rx = 1'b0;
  endtask

  task automatic test_glitch;
    int e0, s;
    @(negedge clk);
    e0 = err_cnt;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (vld_rx !== 1'b0 || err_cnt != e0) begin errors++; $display("FAIL glitch_out: got vld=%b errs=%0d want 0/%0d", vld_rx, err_cnt, e0); end
    s = cyc + 1;
    fork
      send_frame(8'h5A, 1'b1);
      begin
        wait_edge(s + COMP);
        checks++; if (vld_rx !== 1'b1 || d_rx !== 8'h5A) begin errors++; $display("FAIL glitch_next: got vld=%b d=%h want 1/5a", vld_rx, d_rx); end
      end
    join
    rdy_rx = 1'b1;
    @(negedge clk);
    rdy_rx = 1'b0;
  endtask

  task automatic test_break;
    int s, e0;
    @(negedge clk);
    e0 = err_cnt;
    s = cyc + 1;
    fork
      send_frame(8'h3C, 1'b0);
      begin
        wait_edge(s + COMP - 1);
        checks++; if (err_rx !== 1'b0) begin errors++; $display("FAIL brk_err_early: got %b want 0", err_rx); end
        wait_edge(s + COMP);
        checks++; if (err_rx !== 1'b1) begin errors++; $display("FAIL brk_err: got %b want 1", err_rx); end
        wait_edge(s + COMP + 1);
        checks++; if (err_rx !== 1'b0) begin errors++; $display("FAIL brk_err_width: got %b want 0", err_rx); end
      end
    join
    repeat (50) @(negedge clk);
    checks++; if (vld_rx !== 1'b0 || err_cnt != e0 + 1) begin errors++; $display("FAIL brk_hold: got vld=%b errs=%0d want 0/%0d", vld_rx, err_cnt, e0 + 1); end
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    s = cyc + 1;
    fork
      send_frame(8'h81, 1'b1);
      begin
        wait_edge(s + COMP);
        checks++; if (vld_rx !== 1'b1 || d_rx !== 8'h81) begin errors++; $display("FAIL brk_next: got vld=%b d=%h want 1/81", vld_rx, d_rx); end
      end
    join
    rdy_rx = 1'b1;
    @(negedge clk);
    rdy_rx = 1'b0;
  endtask

  task automatic test_overrun;
    int s1, s2, o0;
    @(negedge clk);
    rdy_rx = 1'b0;
    o0 = ovr_cnt;
    s1 = cyc + 1;
    s2 = s1 + COMP + 6;
    fork
      begin send_frame(8'h3C, 1'b1); send_frame(8'hC3, 1'b1); end
      begin
        wait_edge(s2 + COMP - 1);
        checks++; if (ovr_rx !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", ovr_rx); end
        wait_edge(s2 + COMP);
        checks++; if (ovr_rx !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b want 1", ovr_rx); end
        checks++; if (vld_rx !== 1'b1 || d_rx !== 8'h3C) begin errors++; $display("FAIL ovr_keep: got vld=%b d=%h want 1/3c", vld_rx, d_rx); end
        wait_edge(s2 + COMP + 1);
        checks++; if (ovr_rx !== 1'b0) begin errors++; $display("FAIL ovr_width: got %b want 0", ovr_rx); end
      end
    join
    checks++; if (ovr_cnt != o0 + 1 || d_rx !== 8'h3C) begin errors++; $display("FAIL ovr_count: got ovrs=%0d d=%h want %0d/3c", ovr_cnt, d_rx, o0 + 1); end
    rdy_rx = 1'b1;
    @(negedge clk);
    rdy_rx = 1'b0;
  endtask

  task automatic test_back_to_back;
    int s1, s2, o0, v0;
    @(negedge clk);
    rdy_rx = 1'b1;
    o0 = ovr_cnt;
    v0 = vld_hi_cnt;
    s1 = cyc + 1;
    s2 = s1 + COMP + 6;
    fork
      begin send_frame(8'h3C, 1'b1); send_frame(8'hC3, 1'b1); end
      begin
        wait_edge(s1 + COMP);
        checks++; if (vld_rx !== 1'b1 || d_rx !== 8'h3C) begin errors++; $display("FAIL b2b_first: got vld=%b d=%h want 1/3c", vld_rx, d_rx); end
        wait_edge(s1 + COMP + 1);
        checks++; if (vld_rx !== 1'b0) begin errors++; $display("FAIL b2b_first_clr: got %b want 0", vld_rx); end
        wait_edge(s2 + COMP);
        checks++; if (vld_rx !== 1'b1 || d_rx !== 8'hC3) begin errors++; $display("FAIL b2b_second: got vld=%b d=%h want 1/c3", vld_rx, d_rx); end
      end
    join
    @(negedge clk);
    checks++; if (vld_hi_cnt != v0 + 2 || ovr_cnt != o0) begin errors++; $display("FAIL b2b_counts: got vld_cycles=%0d ovrs=%0d want %0d/%0d", vld_hi_cnt - v0, ovr_cnt - o0, 2, 0); end
    rdy_rx = 1'b0;
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b;
    int s, e0, o0;
    b = 8'h96;
    @(negedge clk);
    rdy_rx = 1'b0;
    rxd = 1'b0;
    repeat (BC) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rxd = b[k];
      repeat (BC) @(negedge clk);
    end
    rxd = b[4];
    repeat (BC / 2) @(negedge clk);
    rstn = 1'b0;
    rxd  = 1'b1;
    #1;
    checks++; if (vld_rx !== 1'b0 || d_rx !== 8'h00 || err_rx !== 1'b0 || ovr_rx !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got vld=%b d=%h err=%b ovr=%b want 0/00/0/0", vld_rx, d_rx, err_rx, ovr_rx);
    end
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    e0 = err_cnt;
    o0 = ovr_cnt;
    repeat (BC * 10) @(negedge clk);
    checks++; if (vld_rx !== 1'b0 || err_cnt != e0 || ovr_cnt != o0) begin
      errors++; $display("FAIL rst_mid_quiet: got vld=%b errs=%0d ovrs=%0d want 0/%0d/%0d", vld_rx, err_cnt, ovr_cnt, e0, o0);
    end
    s = cyc + 1;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_edge(s + COMP);
        checks++; if (vld_rx !== 1'b1 || d_rx !== 8'hFF) begin errors++; $display("FAIL rst_mid_next: got vld=%b d=%h want 1/ff", vld_rx, d_rx); end
      end
    join
    rdy_rx = 1'b1;
    @(negedge clk);
    rdy_rx = 1'b0;
  endtask

  task automatic test_random;
    @(negedge clk);
    done = 1'b0;
    fork
      begin
        logic [7:0] b;
        logic       good;
        for (int i = 0; i < 12; i++) begin
          b    = 8'($urandom);
          good = ($urandom_range(0, 4) != 0);
          send_frame(b, good);
          if (!good) begin
            rxd = 1'b1;
            repeat (4) @(negedge clk);
          end else begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
          end
        end
        repeat (4) @(negedge clk);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          rdy_rx = ($urandom_range(0, 3) == 0);
        end
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          checks++; if (vld_rx !== exp_vld) begin errors++; $display("FAIL rnd_vld @%0d: got %b want %b", cyc, vld_rx, exp_vld); end
          checks++; if (err_rx !== exp_err) begin errors++; $display("FAIL rnd_err @%0d: got %b want %b", cyc, err_rx, exp_err); end
          checks++; if (ovr_rx !== exp_ovr) begin errors++; $display("FAIL rnd_ovr @%0d: got %b want %b", cyc, ovr_rx, exp_ovr); end
          if (exp_vld) begin
            checks++; if (d_rx !== exp_d) begin errors++; $display("FAIL rnd_data @%0d: got %h want %h", cyc, d_rx, exp_d); end
          end
        end
      end
    join
    rdy_rx = 1'b1;
    repeat (2) @(negedge clk);
    rdy_rx = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_glitch();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BIT_CYC, default 16, clock cycles per serial bit; SHALL be even and >= 4.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 rxd  input  1  serial line, asynchronous to clk, idle high.
REQ-005 rdy_rx  input  1  consumer ready to take d_rx.
REQ-006 vld_rx  output  1  d_rx holds an unconsumed byte.
REQ-007 d_rx  output  8  received byte.
REQ-008 err_rx  output  1  one-cycle pulse on framing error.
REQ-009 ovr_rx  output  1  one-cycle pulse on overrun.

Function
REQ-010 Frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 rxd SHALL pass through a 2-flop synchronizer; both flops reset to 1. The FSM SHALL use only the second flop's output (rxs).
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, BRK. A bit-cycle counter of width clog2(BIT_CYC) and a 3-bit bit index SHALL be used.
REQ-013 IDLE: when rxs=0, go to START and clear the counter.
REQ-014 START: sample rxs when the counter reaches BIT_CYC/2-1. If 1, treat as a glitch and return to IDLE with no output. If 0, go to DATA, clear the counter, and set the bit index to 0.
REQ-015 DATA: sample rxs each time the counter reaches BIT_CYC-1, then clear the counter. Shift the sample into the MSB of an 8-bit shift register, shifting right. After index 7, go to STOP.
REQ-016 STOP: sample rxs when the counter reaches BIT_CYC-1. If 1, complete the byte and go to IDLE. If 0, pulse err_rx for 1 cycle, discard the byte, and go to BRK.
REQ-017 BRK: remain until rxs=1, then go to IDLE; no new frame SHALL start while in BRK.
REQ-018 Timing: let edge 0 be the first rising edge that captures rxd=0 into sync flop 1. The start bit SHALL be sampled at edge 2+BIT_CYC/2. Data bit k (k=0..7) SHALL be sampled at edge 2+BIT_CYC/2+(k+1)*BIT_CYC. The stop bit SHALL be sampled at edge 2+BIT_CYC/2+9*BIT_CYC.
REQ-019 On byte completion with vld_rx=0, d_rx SHALL be loaded and vld_rx set at the stop-sample edge.
REQ-020 Handshake: a transfer occurs on a clk edge with vld_rx&&rdy_rx. vld_rx SHALL then clear unless a new byte completes on that same edge. d_rx SHALL be stable while vld_rx=1 and no transfer occurs.
REQ-021 Simultaneous completion and transfer: d_rx SHALL load the new byte, vld_rx SHALL stay 1, and ovr_rx SHALL stay 0.
REQ-022 Completion while vld_rx=1 and no transfer: the new byte SHALL be discarded, d_rx and vld_rx SHALL be kept, and ovr_rx SHALL pulse 1 cycle.
REQ-023 Reception SHALL continue independent of rdy_rx; rdy_rx SHALL never stall the FSM.
REQ-024 err_rx and ovr_rx SHALL be registered and never high for more than one consecutive cycle per event.

Reset
REQ-025 While rstn=0: FSM=IDLE, counter=0, index=0, shift register=0, sync flops=1, d_rx=8'h00, vld_rx=0, err_rx=0, ovr_rx=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately with no vld_rx, err_rx or ovr_rx.
REQ-027 After release, a line held low SHALL be treated as a start edge only via IDLE, with normal glitch rejection.

Verification (BIT_CYC=16)
REQ-028 Send 0xA5 with rdy_rx=0 -> vld_rx rises at edge 154, d_rx=8'hA5, held until rdy_rx=1, cleared on that edge.
REQ-029 Pulse rxd low for 4 cycles, then high -> START rejects it, no vld_rx/err_rx, FSM back in IDLE; a following 0x5A frame is received correctly.
REQ-030 Send frame 0x3C with stop bit 0, then hold rxd low 50 cycles -> err_rx single pulse at the stop edge, vld_rx stays 0, no new frame until rxd=1; then 0x81 is received correctly.
REQ-031 Two back-to-back frames 0x3C, 0xC3 with rdy_rx=0 -> d_rx=8'h3C retained, ovr_rx pulses once at the second stop edge, 0xC3 lost.
REQ-032 Two back-to-back frames with rdy_rx=1 -> vld_rx high 1 cycle for each, d_rx 0x3C then 0xC3, no ovr_rx.
REQ-033 Assert rstn=0 at data bit 4 of a frame, release 5 cycles later with rxd=1 -> all outputs at reset values; the next full frame 0xFF is received correctly.
